// File: rtl/watchdog_gen2.sv
// watchdog_gen2: 68k watchdog with programmable hold/timeout, address-decoded
// kick register, 68k reset sensing and a sticky/saturating fire record.
// WDCLK is sampled as a tick source; all logic runs on CLK_24M.
// Optional build macro WD_FREEZE_EN adds DBG_FREEZE to pause timeout counting.
module watchdog_gen2 #(
  parameter int unsigned CNT_WIDTH     = 4,
  parameter int unsigned HOLD_TICKS    = 8,
  parameter int unsigned TIMEOUT_TICKS = 8,
  parameter logic [23:0] KICK_ADDR     = 24'h300001,
  parameter logic [23:0] ADDR_MASK     = 24'hFE1FFE,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic        CLK_24M,
  input  logic        nRST,
  input  logic        WDCLK,
  input  logic        nLDS,
  input  logic        RW,
  input  logic [23:1] M68K_ADDR,
  input  logic        nRESET_IN,
`ifdef WD_FREEZE_EN
  input  logic        DBG_FREEZE,
`endif
  output logic        nRESET,
  output logic        nHALT,
  output logic        WD_FIRED,
  output logic [7:0]  FIRE_CNT
);

  localparam int unsigned SL = SYNC_STAGES - 1;
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST    = CNT_WIDTH'(HOLD_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_TICKS - 1);
  localparam logic [23:0] KICK_MATCH = KICK_ADDR & ADDR_MASK;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 state;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [SYNC_STAGES-1:0] wdclk_sync;
  logic [SYNC_STAGES-1:0] nlds_sync;
  logic [SYNC_STAGES-1:0] rin_sync;
  logic                   wdclk_prev;
  logic                   nlds_prev;
  logic                   rin_prev;
  logic                   kick;

  logic        tick_c;
  logic        lds_fall_c;
  logic        rin_fall_c;
  logic [23:0] addr_c;
  logic        addr_hit_c;
  logic        bus_kick_c;
  logic        sense_kick_c;
  logic        freeze_c;

`ifdef WD_FREEZE_EN
  assign freeze_c = DBG_FREEZE;
`else
  assign freeze_c = 1'b0;
`endif

  // Synchronise asynchronous inputs and keep last synchronised value for edge detect
  always_ff @(posedge CLK_24M or negedge nRST) begin
    if (!nRST) begin
      wdclk_sync <= '0;
      nlds_sync  <= '1;
      rin_sync   <= '1;
      wdclk_prev <= 1'b0;
      nlds_prev  <= 1'b1;
      rin_prev   <= 1'b1;
    end else begin
      wdclk_sync <= {wdclk_sync[SYNC_STAGES-2:0], WDCLK};
      nlds_sync  <= {nlds_sync[SYNC_STAGES-2:0], nLDS};
      rin_sync   <= {rin_sync[SYNC_STAGES-2:0], nRESET_IN};
      wdclk_prev <= wdclk_sync[SL];
      nlds_prev  <= nlds_sync[SL];
      rin_prev   <= rin_sync[SL];
    end
  end

  assign tick_c       = wdclk_sync[SL] & ~wdclk_prev;
  assign lds_fall_c   = ~nlds_sync[SL] & nlds_prev;
  assign rin_fall_c   = ~rin_sync[SL] & rin_prev;
  assign addr_c       = {M68K_ADDR, 1'b0};
  assign addr_hit_c   = ((addr_c & ADDR_MASK) == KICK_MATCH);
  assign bus_kick_c   = lds_fall_c & ~RW & addr_hit_c;
  assign sense_kick_c = (state == ST_RUN) & nRESET & rin_fall_c;

  // One-cycle kick pulse per strobe edge or sensed external reset
  always_ff @(posedge CLK_24M or negedge nRST) begin
    if (!nRST) begin
      kick <= 1'b0;
    end else begin
      kick <= bus_kick_c | sense_kick_c;
    end
  end

  // Hold/run state machine with tick counter and fire bookkeeping
  always_ff @(posedge CLK_24M or negedge nRST) begin
    if (!nRST) begin
      state    <= ST_HOLD;
      cnt      <= '0;
      nRESET   <= 1'b0;
      nHALT    <= 1'b0;
      WD_FIRED <= 1'b0;
      FIRE_CNT <= 8'd0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (tick_c) begin
            if (cnt == HOLD_LAST) begin
              state  <= ST_RUN;
              cnt    <= '0;
              nRESET <= 1'b1;
              nHALT  <= 1'b1;
            end else begin
              cnt <= cnt + CNT_WIDTH'(1);
            end
          end
        end
        ST_RUN: begin
          if (kick) begin
            cnt <= '0;
          end else if (tick_c && !freeze_c) begin
            if (cnt == TIMEOUT_LAST) begin
              state    <= ST_HOLD;
              cnt      <= '0;
              nRESET   <= 1'b0;
              nHALT    <= 1'b0;
              WD_FIRED <= 1'b1;
              if (FIRE_CNT != 8'hFF) begin
                FIRE_CNT <= FIRE_CNT + 8'd1;
              end
            end else begin
              cnt <= cnt + CNT_WIDTH'(1);
            end
          end
        end
        default: begin
          state  <= ST_HOLD;
          cnt    <= '0;
          nRESET <= 1'b0;
          nHALT  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_watchdog_gen2.sv
// Directed self-checking bench for watchdog_gen2 (default parameters).
// Define WD_FREEZE_EN for both files to exercise DBG_FREEZE.
`timescale 1ns/1ps
module tb_watchdog_gen2;

  logic        CLK_24M = 1'b0;
  logic        nRST = 1'b0;
  logic        WDCLK = 1'b0;
  logic        nLDS = 1'b1;
  logic        RW = 1'b1;
  logic [23:1] M68K_ADDR = '0;
  logic        nRESET_IN = 1'b1;
`ifdef WD_FREEZE_EN
  logic        DBG_FREEZE = 1'b0;
`endif
  logic        nRESET;
  logic        nHALT;
  logic        WD_FIRED;
  logic [7:0]  FIRE_CNT;

  int checks = 0;
  int failures = 0;
  int exp_fires = 0;

  watchdog_gen2 dut (
    .CLK_24M   (CLK_24M),
    .nRST      (nRST),
    .WDCLK     (WDCLK),
    .nLDS      (nLDS),
    .RW        (RW),
    .M68K_ADDR (M68K_ADDR),
    .nRESET_IN (nRESET_IN),
`ifdef WD_FREEZE_EN
    .DBG_FREEZE(DBG_FREEZE),
`endif
    .nRESET    (nRESET),
    .nHALT     (nHALT),
    .WD_FIRED  (WD_FIRED),
    .FIRE_CNT  (FIRE_CNT)
  );

  always #5 CLK_24M = ~CLK_24M;

  // One WDCLK period: 4 cycles high, 4 low; the counter has updated on return
  task automatic wd_tick();
    WDCLK = 1'b1;
    repeat (4) @(negedge CLK_24M);
    WDCLK = 1'b0;
    repeat (4) @(negedge CLK_24M);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) wd_tick();
  endtask

  task automatic bus_write(input logic [23:0] a, input logic rw);
    M68K_ADDR = a[23:1];
    RW = rw;
    nLDS = 1'b0;
    repeat (4) @(negedge CLK_24M);
    nLDS = 1'b1;
    RW = 1'b1;
    repeat (3) @(negedge CLK_24M);
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (3) @(negedge CLK_24M);
    checks++; if (nRESET !== 1'b0) begin failures++; $display("FAIL rst_nreset got %b exp 0", nRESET); end
    checks++; if (nHALT !== 1'b0) begin failures++; $display("FAIL rst_nhalt got %b exp 0", nHALT); end
    checks++; if (WD_FIRED !== 1'b0) begin failures++; $display("FAIL rst_fired got %b exp 0", WD_FIRED); end
    checks++; if (FIRE_CNT !== 8'd0) begin failures++; $display("FAIL rst_firecnt got %0d exp 0", FIRE_CNT); end
    nRST = 1'b1;
    repeat (2) @(negedge CLK_24M);
    exp_fires = 0;
  endtask

  task automatic test_powerup();
    for (int i = 1; i <= 7; i++) begin
      wd_tick();
      checks++; if (nRESET !== 1'b0) begin failures++; $display("FAIL pu_hold tick %0d got %b exp 0", i, nRESET); end
    end
    wd_tick();
    checks++; if (nRESET !== 1'b1) begin failures++; $display("FAIL pu_release got %b exp 1", nRESET); end
    checks++; if (nHALT !== 1'b1) begin failures++; $display("FAIL pu_nhalt got %b exp 1", nHALT); end
    checks++; if (WD_FIRED !== 1'b0 || FIRE_CNT !== 8'd0) begin failures++; $display("FAIL pu_fired got %b/%0d exp 0/0", WD_FIRED, FIRE_CNT); end
  endtask

  task automatic test_timeout();
    ticks(7);
    checks++; if (nRESET !== 1'b1) begin failures++; $display("FAIL to_before got %b exp 1", nRESET); end
    wd_tick();
    exp_fires++;
    checks++; if (nRESET !== 1'b0 || nHALT !== 1'b0) begin failures++; $display("FAIL to_fire got %b%b exp 00", nRESET, nHALT); end
    checks++; if (WD_FIRED !== 1'b1) begin failures++; $display("FAIL to_fired got %b exp 1", WD_FIRED); end
    checks++; if (FIRE_CNT !== 8'(exp_fires)) begin failures++; $display("FAIL to_cnt got %0d exp %0d", FIRE_CNT, exp_fires); end
    ticks(7);
    checks++; if (nRESET !== 1'b0) begin failures++; $display("FAIL to_hold got %b exp 0", nRESET); end
    wd_tick();
    checks++; if (nRESET !== 1'b1) begin failures++; $display("FAIL to_rerun got %b exp 1", nRESET); end
  endtask

  task automatic test_saturate();
    for (int i = 2; i <= 300; i++) begin
      ticks(8);
      exp_fires = (i > 255) ? 255 : i;
      checks++; if (FIRE_CNT !== 8'(exp_fires)) begin failures++; $display("FAIL sat_cnt fire %0d got %0d exp %0d", i, FIRE_CNT, exp_fires); end
      ticks(8);
    end
    checks++; if (FIRE_CNT !== 8'd255) begin failures++; $display("FAIL sat_final got %0d exp 255", FIRE_CNT); end
    nRST = 1'b0;
    repeat (2) @(negedge CLK_24M);
    nRST = 1'b1;
    repeat (2) @(negedge CLK_24M);
    exp_fires = 0;
    ticks(8);
  endtask

  task automatic test_kick();
    for (int r = 0; r < 20; r++) begin
      ticks(5);
      bus_write(24'h300001, 1'b0);
      checks++; if (nRESET !== 1'b1) begin failures++; $display("FAIL kick_run round %0d got %b exp 1", r, nRESET); end
    end
    checks++; if (FIRE_CNT !== 8'd0) begin failures++; $display("FAIL kick_cnt got %0d exp 0", FIRE_CNT); end
  endtask

  task automatic test_reject(input logic [23:0] a, input logic rw);
    ticks(4);
    bus_write(a, rw);
    ticks(3);
    checks++; if (nRESET !== 1'b1) begin failures++; $display("FAIL rej_early addr %h rw %b got %b exp 1", a, rw, nRESET); end
    wd_tick();
    exp_fires++;
    checks++; if (nRESET !== 1'b0) begin failures++; $display("FAIL rej_fire addr %h rw %b got %b exp 0", a, rw, nRESET); end
    checks++; if (FIRE_CNT !== 8'(exp_fires)) begin failures++; $display("FAIL rej_cnt got %0d exp %0d", FIRE_CNT, exp_fires); end
    ticks(8);
  endtask

  task automatic test_mirror();
    ticks(4);
    bus_write(24'h31E001, 1'b0);
    ticks(7);
    checks++; if (nRESET !== 1'b1) begin failures++; $display("FAIL mir_kept got %b exp 1", nRESET); end
    wd_tick();
    exp_fires++;
    checks++; if (nRESET !== 1'b0) begin failures++; $display("FAIL mir_fire got %b exp 0", nRESET); end
    ticks(8);
  endtask

  task automatic test_back_to_back();
    ticks(7);
    M68K_ADDR = 23'h180000;
    RW = 1'b0;
    nLDS = 1'b0;
    @(negedge CLK_24M);
    WDCLK = 1'b1;
    repeat (4) @(negedge CLK_24M);
    WDCLK = 1'b0;
    nLDS = 1'b1;
    RW = 1'b1;
    repeat (4) @(negedge CLK_24M);
    checks++; if (nRESET !== 1'b1) begin failures++; $display("FAIL b2b_nofire got %b exp 1", nRESET); end
    checks++; if (FIRE_CNT !== 8'(exp_fires)) begin failures++; $display("FAIL b2b_cnt got %0d exp %0d", FIRE_CNT, exp_fires); end
    ticks(7);
    checks++; if (nRESET !== 1'b1) begin failures++; $display("FAIL b2b_cleared got %b exp 1", nRESET); end
    wd_tick();
    exp_fires++;
    checks++; if (nRESET !== 1'b0) begin failures++; $display("FAIL b2b_fire got %b exp 0", nRESET); end
    ticks(8);
  endtask

  task automatic test_reset_sense();
    ticks(6);
    nRESET_IN = 1'b0;
    repeat (4) @(negedge CLK_24M);
    nRESET_IN = 1'b1;
    repeat (3) @(negedge CLK_24M);
    checks++; if (FIRE_CNT !== 8'(exp_fires)) begin failures++; $display("FAIL sense_cnt got %0d exp %0d", FIRE_CNT, exp_fires); end
    ticks(7);
    checks++; if (nRESET !== 1'b1) begin failures++; $display("FAIL sense_cleared got %b exp 1", nRESET); end
    wd_tick();
    exp_fires++;
    checks++; if (nRESET !== 1'b0) begin failures++; $display("FAIL sense_fire got %b exp 0", nRESET); end
  endtask

  task automatic test_rst_mid_hold();
    ticks(4);
    nRST = 1'b0;
    @(negedge CLK_24M);
    checks++; if (WD_FIRED !== 1'b0 || FIRE_CNT !== 8'd0) begin failures++; $display("FAIL mid_clear got %b/%0d exp 0/0", WD_FIRED, FIRE_CNT); end
    checks++; if (nRESET !== 1'b0 || nHALT !== 1'b0) begin failures++; $display("FAIL mid_drive got %b%b exp 00", nRESET, nHALT); end
    nRST = 1'b1;
    exp_fires = 0;
    repeat (2) @(negedge CLK_24M);
    ticks(7);
    checks++; if (nRESET !== 1'b0) begin failures++; $display("FAIL mid_hold got %b exp 0", nRESET); end
    wd_tick();
    checks++; if (nRESET !== 1'b1 || nHALT !== 1'b1) begin failures++; $display("FAIL mid_release got %b%b exp 11", nRESET, nHALT); end
  endtask

`ifdef WD_FREEZE_EN
  task automatic test_freeze();
    DBG_FREEZE = 1'b1;
    ticks(50);
    checks++; if (nRESET !== 1'b1 || FIRE_CNT !== 8'd0) begin failures++; $display("FAIL frz_hold got %b/%0d exp 1/0", nRESET, FIRE_CNT); end
    DBG_FREEZE = 1'b0;
    ticks(7);
    checks++; if (nRESET !== 1'b1) begin failures++; $display("FAIL frz_after got %b exp 1", nRESET); end
    wd_tick();
    checks++; if (nRESET !== 1'b0) begin failures++; $display("FAIL frz_fire got %b exp 0", nRESET); end
  endtask
`endif

  initial begin
    @(negedge CLK_24M);
    test_reset();
    test_powerup();
    test_timeout();
    test_saturate();
    test_kick();
    test_reject(24'h300001, 1'b1);
    test_reject(24'h300003, 1'b0);
    test_mirror();
    test_reject(24'h700001, 1'b0);
    test_back_to_back();
    test_reset_sense();
    test_rst_mid_hold();
`ifdef WD_FREEZE_EN
    test_freeze();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
